// File: rtl/bounded_updown_counter_pkg.sv
// Shared constants for bounded up/down counter stages and the
// digit counters built by cascading them.
package bounded_updown_counter_pkg;

  localparam bit WRAP_MODE = 1'b1;
  localparam bit SAT_MODE  = 1'b0;

  // BCD digit stage
  localparam int BCD_N   = 4;
  localparam int BCD_MAX = 9;

  // Clock-style cascade stages: tens of seconds/minutes and hours
  localparam int TENS_MAX  = 5;
  localparam int HOURS_N   = 5;
  localparam int HOURS_MAX = 23;

endpackage

// File: rtl/bounded_updown_counter_n_bit_counter.sv
// Combinational N-bit incrementer/decrementer feeding the bounded counter
// register; bound handling is left to the caller.
module N_bit_counter #(
  parameter int N = 4
) (
  input  logic [N-1:0] count_i,
  input  logic         up_i,
  output logic [N-1:0] result_o
);

  always_comb begin
    if (up_i) begin
      result_o = count_i + N'(1);
    end else begin
      result_o = count_i - N'(1);
    end
  end

endmodule

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter stage: count register over [0, MAX] with wrap or
// saturation, combinational carry/borrow for cascading, registered at_bound.
module bounded_updown_counter
  import bounded_updown_counter_pkg::*;
#(
  parameter int N    = BCD_N,
  parameter int MAX  = BCD_MAX,
  parameter bit WRAP = WRAP_MODE
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic         load_i,
  input  logic [N-1:0] load_val_i,
  output logic [N-1:0] count_o,
  output logic         co_o,
  output logic         at_bound_o
);

  localparam logic [N-1:0] MAX_C = N'(MAX);

  if (N < 2 || MAX < 1 || MAX >= (2 ** N)) begin : g_bad_params
    $error("bounded_updown_counter: MAX must lie in [1, 2^N-1] with N >= 2");
  end

  logic [N-1:0] count_q, count_d;
  logic         at_bound_q, at_bound_d;
  logic [N-1:0] step_s;
  logic         at_max_s, at_zero_s;
  logic         co_s;

  N_bit_counter #(.N(N)) u_step (
    .count_i  (count_q),
    .up_i     (up_i),
    .result_o (step_s)
  );

  always_comb begin
    count_d    = count_q;
    at_max_s   = (count_q == MAX_C);
    at_zero_s  = (count_q == '0);
    if (load_i) begin
      count_d = (load_val_i > MAX_C) ? MAX_C : load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        if (at_max_s) begin
          count_d = WRAP ? '0 : MAX_C;
        end else begin
          count_d = step_s;
        end
      end else begin
        if (at_zero_s) begin
          count_d = WRAP ? MAX_C : '0;
        end else begin
          count_d = step_s;
        end
      end
    end else begin
      count_d = count_q;
    end
    // Saturating stages still raise co so the next stage sees the overflow.
    co_s       = en_i & ~load_i & ~reset_i & (up_i ? at_max_s : at_zero_s);
    at_bound_d = up_i ? (count_d == MAX_C) : (count_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q    <= '0;
      at_bound_q <= ~up_i;
    end else begin
      count_q    <= count_d;
      at_bound_q <= at_bound_d;
    end
  end

  assign count_o    = count_q;
  assign co_o       = co_s;
  assign at_bound_o = at_bound_q;

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Self-checking bench: directed and random steps on wrap/saturate instances
// against an arithmetic model, plus a two-digit 0..59 cascade.
module tb_bounded_updown_counter;
  import bounded_updown_counter_pkg::*;

  localparam int MAXV = BCD_MAX;

  logic       clk;
  logic       reset, en, up, load;
  logic [3:0] load_val;
  logic [3:0] cnt_w, cnt_s;
  logic       co_w, co_s, ab_w, ab_s;

  logic       c_reset, c_en;
  logic [3:0] c_lo, c_hi;
  logic       c_lo_co, c_hi_co, c_lo_ab, c_hi_ab;

  int n_checks = 0;
  int n_fail   = 0;
  int m_w, m_s;
  bit mab_w, mab_s;
  int total;

  bounded_updown_counter #(.N(BCD_N), .MAX(BCD_MAX), .WRAP(WRAP_MODE)) dut_wrap (
    .clk_i(clk), .reset_i(reset), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(load_val), .count_o(cnt_w), .co_o(co_w), .at_bound_o(ab_w));

  bounded_updown_counter #(.N(BCD_N), .MAX(BCD_MAX), .WRAP(SAT_MODE)) dut_sat (
    .clk_i(clk), .reset_i(reset), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(load_val), .count_o(cnt_s), .co_o(co_s), .at_bound_o(ab_s));

  bounded_updown_counter #(.N(4), .MAX(BCD_MAX), .WRAP(WRAP_MODE)) dut_lo (
    .clk_i(clk), .reset_i(c_reset), .en_i(c_en), .up_i(1'b1), .load_i(1'b0),
    .load_val_i(4'd0), .count_o(c_lo), .co_o(c_lo_co), .at_bound_o(c_lo_ab));

  bounded_updown_counter #(.N(4), .MAX(TENS_MAX), .WRAP(WRAP_MODE)) dut_hi (
    .clk_i(clk), .reset_i(c_reset), .en_i(c_lo_co), .up_i(1'b1), .load_i(1'b0),
    .load_val_i(4'd0), .count_o(c_hi), .co_o(c_hi_co), .at_bound_o(c_hi_ab));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counting rules written as plain modular/clamped arithmetic.
  function automatic int model_next(int c, bit wrap, bit r, bit l, int lv, bit e, bit u);
    if (r) return 0;
    if (l) return (lv > MAXV) ? MAXV : lv;
    if (!e) return c;
    if (wrap) return u ? (c + 1) % (MAXV + 1) : (c + MAXV) % (MAXV + 1);
    return u ? ((c < MAXV) ? c + 1 : MAXV) : ((c > 0) ? c - 1 : 0);
  endfunction

  function automatic bit model_co(int c, bit r, bit l, bit e, bit u);
    return e && !l && !r && (u ? (c == MAXV) : (c == 0));
  endfunction

  // One clock: drive, check co mid-cycle, then check registered outputs.
  task automatic do_cycle(input bit r, input bit l, input int lv, input bit e, input bit u);
    reset = r; load = l; load_val = 4'(lv); en = e; up = u;
    @(negedge clk);
    chk("co_wrap", {31'd0, co_w}, {31'd0, model_co(m_w, r, l, e, u)});
    chk("co_sat",  {31'd0, co_s}, {31'd0, model_co(m_s, r, l, e, u)});
    @(posedge clk);
    m_w = model_next(m_w, 1'b1, r, l, lv, e, u);
    m_s = model_next(m_s, 1'b0, r, l, lv, e, u);
    mab_w = r ? !u : (u ? (m_w == MAXV) : (m_w == 0));
    mab_s = r ? !u : (u ? (m_s == MAXV) : (m_s == 0));
    #1;
    chk("count_wrap", {28'd0, cnt_w}, m_w);
    chk("count_sat",  {28'd0, cnt_s}, m_s);
    chk("at_bound_wrap", {31'd0, ab_w}, {31'd0, mab_w});
    chk("at_bound_sat",  {31'd0, ab_s}, {31'd0, mab_s});
  endtask

  initial begin
    m_w = 0; m_s = 0;
    reset = 1'b1; load = 1'b0; load_val = 4'd0; en = 1'b0; up = 1'b1;
    c_reset = 1'b1; c_en = 1'b0;
    @(posedge clk); #1;

    // Reset state with both directions
    do_cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);
    chk("reset_count", {28'd0, cnt_w}, 32'd0);
    chk("reset_ab_up", {31'd0, ab_w}, 32'd0);
    do_cycle(1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("reset_ab_down", {31'd0, ab_w}, 32'd1);

    // Count up 12 cycles with wrap
    for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
    chk("up12_final", {28'd0, cnt_w}, 32'd2);

    // Down from 0: 9, 8, 7
    do_cycle(1'b0, 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    chk("down3_final", {28'd0, cnt_w}, 32'd7);

    // Saturate up from 8
    do_cycle(1'b0, 1'b1, 8, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
    chk("sat_hold_max", {28'd0, cnt_s}, 32'd9);

    // Load clamp, then load beats en
    do_cycle(1'b0, 1'b1, 14, 1'b0, 1'b1);
    chk("load_clamp", {28'd0, cnt_w}, 32'd9);
    do_cycle(1'b0, 1'b1, 3, 1'b1, 1'b1);
    chk("load_with_en", {28'd0, cnt_w}, 32'd3);

    // Reset beats load and en
    do_cycle(1'b0, 1'b1, 6, 1'b0, 1'b1);
    do_cycle(1'b1, 1'b1, 5, 1'b1, 1'b1);
    chk("reset_priority", {28'd0, cnt_w}, 32'd0);

    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(31) == 0), ($urandom_range(7) == 0),
               int'($urandom_range(15)), ($urandom_range(3) != 0),
               1'($urandom_range(1)));
    end

    // Two-digit cascade 0..59
    c_reset = 1'b1; c_en = 1'b0;
    @(posedge clk); #1;
    c_reset = 1'b0; c_en = 1'b1;
    total = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("casc_lo_co", {31'd0, c_lo_co}, {31'd0, (total % 10) == 9});
      chk("casc_hi_co", {31'd0, c_hi_co}, {31'd0, total == 59});
      if (i == 59) chk("casc_hi_co_at59", {31'd0, c_hi_co}, 32'd1);
      @(posedge clk);
      total = (total + 1) % 60;
      #1;
      chk("casc_lo", {28'd0, c_lo}, total % 10);
      chk("casc_hi", {28'd0, c_hi}, total / 10);
    end
    chk("casc_lo_end", {28'd0, c_lo}, 32'd0);
    chk("casc_hi_end", {28'd0, c_hi}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bounded_updown_counter.md
# bounded_updown_counter

Registered, bounded up/down counter stage that holds the count state and feeds it to the combinational `N_bit_counter` incrementer/decrementer. It then registers the incremented or decremented result back, with modulo wrap or saturation at programmable bounds. It is the building block for cascaded digit counters such as BCD seconds/minutes digits and buffer address counters. Its combinational carry/borrow output drives the `en` of the next stage.

## Interface
- `N`, 4: count width in bits (N ≥ 2).
- `MAX`, 9: upper bound, 1 ≤ MAX ≤ 2^N−1; lower bound is fixed at 0.
- `WRAP`, 1: 1 = modulo wrap at bounds, 0 = saturate at bounds.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `en`  in  1  count enable; one step per cycle while high.
- `up`  in  1  direction: 1 = count up, 0 = count down; passed straight to `N_bit_counter`.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  N  value to load.
- `count`  out  N  registered count.
- `co`  out  1  carry/borrow: combinational, high when a step will cross a bound this cycle.
- `at_bound`  out  1  registered: count == MAX when `up`, count == 0 when not `up`.

## Operation
- Priority on each rising edge: `reset` > `load` > `en` > hold.
- `reset`: `count` ← 0. `at_bound` ← 1 if `up` is 0 at that edge, else 0.
- `load`: `count` ← min(`load_val`, MAX). Out-of-range values clamp to MAX. `en` is ignored in that cycle.
- `en`, `up` = 1:
  - if `count` ≠ MAX: `count` ← `count`+1, taken from the `N_bit_counter` result.
  - if `count` == MAX: `count` ← 0 (WRAP=1) or holds MAX (WRAP=0).
- `en`, `up` = 0:
  - if `count` ≠ 0: `count` ← `count`−1.
  - if `count` == 0: `count` ← MAX (WRAP=1) or holds 0 (WRAP=0).
- `co` = `en` & ~`load` & ~`reset` & (`up` ? `count`==MAX : `count`==0). It asserts in both WRAP modes, so cascaded stages still see an overflow request when saturating.
- `at_bound` is recomputed every cycle from the next-state count and the current `up`. A direction change is reflected one cycle later.
- `count` can never leave [0, MAX]. Load clamping guarantees this; no illegal-state recovery is needed.
- Arithmetic: all compares are N-bit unsigned. MAX is truncated to N bits at elaboration; an elaboration check rejects MAX ≥ 2^N.

## Timing
- Latency: 1 cycle from `en`/`load` sampled high to the new `count` visible.
- `co` has zero latency. It is valid in the same cycle as `en` and is intended to feed the next stage's `en` directly. Cascade depth is limited by the `co` chain.
- `reset` asserted mid-count takes effect on the next edge, regardless of `en`/`load`. `co` is forced low while `reset` is high.
- `load` and `en` together: the load wins, `co` = 0, no step.
- Direction reversal (`up` toggles while `en` is high): the step uses the new `up` in that same cycle. There is no pipeline hazard.
- Reset values: `count` = 0; `at_bound` per `up` at reset; `co` is combinational, 0 during reset.

## Structure
- One sub-module: `N_bit_counter`, instantiated with `N` and `up`, input = `count` register. It provides the ±1 value; wrap/saturate selection and the register live in this block.
- Shared package: a `WRAP_MODE`/`SAT_MODE` constant pair and a common BCD digit constant (MAX=9, N=4). Cascaded clock stages also use the package constants MAX=5 and MAX=23 (N=5).
- Next-state mux and `co`/`at_bound` logic sit in a single combinational process; one clocked process holds the register.

## Test plan
- Reset, then `en`=1, `up`=1, N=4, MAX=9, WRAP=1 for 12 cycles → `count` 0,1,…,9,0,1,2. `co`=1 only in the cycle `count`==9.
- `up`=0 from `count`=0, WRAP=1, 3 cycles → `count` 9,8,7. `co`=1 in the first cycle only.
- WRAP=0, `up`=1 from 8, `en` held 4 cycles → `count` 9,9,9,9. `co`=1 while `count`==9 and `en` high.
- `load`=1, `load_val`=14 with MAX=9 → `count`=9 next cycle. `load`+`en` together with `load_val`=3 → `count`=3, `co`=0.
- Assert `reset` while `count`=6 with `en`=1 and `load`=1 → `count`=0 next cycle, `co`=0 during reset.
- Two-stage cascade (MAX=9 feeding MAX=5 via `co`→`en`) counting up from 0 for 60 cycles → high digit steps on each low-digit 9→0. Both digits read 0,0 at cycle 60, and high-stage `co` pulses at 59.
